// File: rtl/tagged_ram_ctl_if.sv
`default_nettype none
// tagged_ram_ctl_if : multiplexed CPU address/data bus between the cpu (master) and the tagged RAM (slave).
// Rev 1.0
interface tagged_ram_ctl_if #(
  parameter int AW = 20,
  parameter int DW = 64,
  parameter int TW = 8
);
  logic [DW-1:0] i_ad;
  logic [TW-1:0] i_tag;
  logic          i_astb;
  logic          i_rd;
  logic          i_wr;
  logic          i_btr;
  logic [DW-1:0] o_data;
  logic [TW-1:0] o_tag;
  logic          o_valid;
  logic [AW-1:0] o_addr;
  logic          o_err;

  modport master (
    output i_ad, i_tag, i_astb, i_rd, i_wr, i_btr,
    input  o_data, o_tag, o_valid, o_addr, o_err
  );

  modport slave (
    input  i_ad, i_tag, i_astb, i_rd, i_wr, i_btr,
    output o_data, o_tag, o_valid, o_addr, o_err
  );
endinterface
`default_nettype wire

// File: rtl/tagged_ram_ctl.sv
`default_nettype none
// tagged_ram_ctl : tagged RAM slave with RD_LAT read pipeline and BTR auto-increment.
// Optional stored parity with sticky o_err under TAGGED_RAM_CTL_PARITY_EN. Rev 1.0
module tagged_ram_ctl #(
  parameter int AW     = 20,
  parameter int DW     = 64,
  parameter int TW     = 8,
  parameter int RD_LAT = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  tagged_ram_ctl_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int LAST  = RD_LAT - 1;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("tagged_ram_ctl: RD_LAT must be in 1..4");
    end
  endgenerate

  logic          do_astb;
  logic          do_wr;
  logic          do_rd;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] mem  [DEPTH];
  logic [TW-1:0] tmem [DEPTH];
  logic          pv_q [RD_LAT];
  logic          pv_d [RD_LAT];
  logic [DW-1:0] pd_q [RD_LAT];
  logic [DW-1:0] pd_d [RD_LAT];
  logic [TW-1:0] pt_q [RD_LAT];
  logic [TW-1:0] pt_d [RD_LAT];

  // One command per cycle: astb beats wr beats rd.
  always_comb begin
    do_astb = bus.i_astb;
    do_wr   = !bus.i_astb && bus.i_wr;
    do_rd   = !bus.i_astb && !bus.i_wr && bus.i_rd;
    addr_d  = addr_q;
    if (do_astb) begin
      addr_d = bus.i_ad[AW-1:0];
    end else if ((do_wr || do_rd) && bus.i_btr) begin
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[addr_q]  <= bus.i_ad;
      tmem[addr_q] <= bus.i_tag;
    end
  end

  // Stage 0 samples the array at the rd edge; the last stage is the output register and holds between reads.
  always_comb begin
    pv_d[0] = do_rd;
    pd_d[0] = mem[addr_q];
    pt_d[0] = tmem[addr_q];
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
    if (!pv_d[LAST]) begin
      pd_d[LAST] = pd_q[LAST];
      pt_d[LAST] = pt_q[LAST];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pt_q[i] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pd_q[i] <= pd_d[i];
        pt_q[i] <= pt_d[i];
      end
    end
  end

  assign bus.o_valid = pv_q[LAST];
  assign bus.o_data  = pd_q[LAST];
  assign bus.o_tag   = pt_q[LAST];
  assign bus.o_addr  = addr_q;

`ifdef TAGGED_RAM_CTL_PARITY_EN
  logic pmem [DEPTH];
  logic pp_q [RD_LAT];
  logic pp_d [RD_LAT];
  logic err_q;
  logic err_d;

  // Plain always so the bench task below may also flip stored bits.
  always @(posedge clk) begin
    if (do_wr) begin
      pmem[addr_q] <= ^{bus.i_tag, bus.i_ad};
    end
  end

  task automatic inject_parity(input logic [AW-1:0] a);
    pmem[a] = ~pmem[a];
  endtask

  always_comb begin
    pp_d[0] = pmem[addr_q];
    for (int i = 1; i < RD_LAT; i++) begin
      pp_d[i] = pp_q[i-1];
    end
    err_d = err_q;
    if (pv_d[LAST] && ((^{pt_d[LAST], pd_d[LAST]}) != pp_d[LAST])) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pp_q[i] <= 1'b0;
      end
    end else begin
      err_q <= err_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pp_q[i] <= pp_d[i];
      end
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tagged_ram_ctl.sv
`default_nettype none
// tb_tagged_ram_ctl : directed vector table on an RD_LAT=1 instance plus pipeline/flush sequences on RD_LAT=3.
// Rev 1.0
module tb_tagged_ram_ctl;

  logic clk;
  logic rst1_n;
  logic rst3_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  tagged_ram_ctl_if #(.AW(20), .DW(64), .TW(8)) b1 ();
  tagged_ram_ctl_if #(.AW(20), .DW(64), .TW(8)) b3 ();

  tagged_ram_ctl #(.AW(20), .DW(64), .TW(8), .RD_LAT(1)) u1 (.clk(clk), .reset(rst1_n), .bus(b1));
  tagged_ram_ctl #(.AW(20), .DW(64), .TW(8), .RD_LAT(3)) u3 (.clk(clk), .reset(rst3_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        astb;
    logic        wr;
    logic        rd;
    logic        btr;
    logic [63:0] ad;
    logic [7:0]  tag;
    logic        e_valid;
    logic [63:0] e_data;
    logic [7:0]  e_tag;
    logic [19:0] e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic a, input logic w, input logic r, input logic b,
                      input logic [63:0] ad, input logic [7:0] tg, input logic ev,
                      input logic [63:0] ed, input logic [7:0] et, input logic [19:0] ea);
    vec_t v;
    v.astb = a; v.wr = w; v.rd = r; v.btr = b; v.ad = ad; v.tag = tg;
    v.e_valid = ev; v.e_data = ed; v.e_tag = et; v.e_addr = ea;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv1(input logic a, input logic w, input logic r, input logic b,
                      input logic [63:0] ad, input logic [7:0] tg);
    @(negedge clk);
    b1.i_astb = a; b1.i_wr = w; b1.i_rd = r; b1.i_btr = b; b1.i_ad = ad; b1.i_tag = tg;
  endtask

  task automatic drv3(input logic a, input logic w, input logic r, input logic b,
                      input logic [63:0] ad, input logic [7:0] tg);
    @(negedge clk);
    b3.i_astb = a; b3.i_wr = w; b3.i_rd = r; b3.i_btr = b; b3.i_ad = ad; b3.i_tag = tg;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ed;
    b1.i_astb = 0; b1.i_wr = 0; b1.i_rd = 0; b1.i_btr = 0; b1.i_ad = '0; b1.i_tag = '0;
    b3.i_astb = 0; b3.i_wr = 0; b3.i_rd = 0; b3.i_btr = 0; b3.i_ad = '0; b3.i_tag = '0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;

    //   astb wr rd btr  ad                      tag    valid data                    tag    addr
    addv(1, 0, 0, 0, 64'h123,                8'h00, 0, 64'h0,                  8'h00, 20'h00123);
    addv(0, 1, 0, 0, 64'hDEADBEEF_01234567,  8'h3C, 0, 64'h0,                  8'h00, 20'h00123);
    addv(0, 0, 1, 0, 64'h0,                  8'h00, 1, 64'hDEADBEEF_01234567,  8'h3C, 20'h00123);
    addv(0, 0, 0, 0, 64'h0,                  8'h00, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'h00123);
    addv(1, 0, 0, 0, 64'hFFFFE,              8'h00, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'hFFFFE);
    addv(0, 1, 0, 1, 64'hA,                  8'h01, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'hFFFFF);
    addv(0, 1, 0, 1, 64'hB,                  8'h02, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'h00000);
    addv(0, 1, 0, 1, 64'hC,                  8'h03, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'h00001);
    addv(1, 0, 0, 0, 64'hFFFFE,              8'h00, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'hFFFFE);
    addv(0, 0, 1, 1, 64'h0,                  8'h00, 1, 64'hA,                  8'h01, 20'hFFFFF);
    addv(0, 0, 1, 1, 64'h0,                  8'h00, 1, 64'hB,                  8'h02, 20'h00000);
    addv(0, 0, 1, 1, 64'h0,                  8'h00, 1, 64'hC,                  8'h03, 20'h00001);
    addv(0, 0, 0, 0, 64'h0,                  8'h00, 0, 64'hC,                  8'h03, 20'h00001);
    addv(1, 0, 0, 0, 64'h55,                 8'h00, 0, 64'hC,                  8'h03, 20'h00055);
    addv(0, 1, 0, 0, 64'h1111,               8'h11, 0, 64'hC,                  8'h03, 20'h00055);
    addv(1, 1, 0, 0, 64'h55,                 8'hEE, 0, 64'hC,                  8'h03, 20'h00055);
    addv(0, 0, 1, 0, 64'h0,                  8'h00, 1, 64'h1111,               8'h11, 20'h00055);
    addv(0, 1, 1, 0, 64'h77,                 8'h99, 0, 64'h1111,               8'h11, 20'h00055);
    addv(0, 0, 1, 0, 64'h0,                  8'h00, 1, 64'h77,                 8'h99, 20'h00055);
    addv(1, 0, 1, 0, 64'h123,                8'h00, 0, 64'h77,                 8'h99, 20'h00123);
    addv(0, 0, 1, 0, 64'h0,                  8'h00, 1, 64'hDEADBEEF_01234567,  8'h3C, 20'h00123);
    addv(0, 0, 0, 1, 64'h0,                  8'h00, 0, 64'hDEADBEEF_01234567,  8'h3C, 20'h00123);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    repeat (5) tick();

    chk("rst1.valid", 64'(b1.o_valid), 64'h0);
    chk("rst1.data",  b1.o_data,       64'h0);
    chk("rst1.tag",   64'(b1.o_tag),   64'h0);
    chk("rst1.addr",  64'(b1.o_addr),  64'h0);
    chk("rst1.err",   64'(b1.o_err),   64'h0);
    chk("rst3.valid", 64'(b3.o_valid), 64'h0);
    chk("rst3.data",  b3.o_data,       64'h0);

    foreach (vq[i]) begin
      drv1(vq[i].astb, vq[i].wr, vq[i].rd, vq[i].btr, vq[i].ad, vq[i].tag);
      tick();
      chk($sformatf("v%0d.valid", i), 64'(b1.o_valid), 64'(vq[i].e_valid));
      chk($sformatf("v%0d.data", i),  b1.o_data,       vq[i].e_data);
      chk($sformatf("v%0d.tag", i),   64'(b1.o_tag),   64'(vq[i].e_tag));
      chk($sformatf("v%0d.addr", i),  64'(b1.o_addr),  64'(vq[i].e_addr));
      chk($sformatf("v%0d.err", i),   64'(b1.o_err),   64'h0);
    end
    drv1(0, 0, 0, 0, 64'h0, 8'h00);

    // RD_LAT=3: four back-to-back BTR reads, valid two edges after each sample edge.
    drv3(1, 0, 0, 0, 64'h200, 8'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv3(0, 1, 0, 1, 64'h1000 + 64'(k), 8'hA0 + 8'(k));
      tick();
    end
    drv3(1, 0, 0, 0, 64'h200, 8'h00);
    tick();
    for (int s = 0; s < 7; s++) begin
      drv3(0, 0, (s < 4), (s < 4), 64'h0, 8'h00);
      tick();
      ed = (s < 2) ? 64'h0 : 64'h1000 + 64'((s > 5) ? 3 : s - 2);
      chk($sformatf("lat3.s%0d.valid", s), 64'(b3.o_valid), 64'((s >= 2 && s <= 5) ? 1 : 0));
      chk($sformatf("lat3.s%0d.data", s),  b3.o_data,       ed);
      chk($sformatf("lat3.s%0d.tag", s),   64'(b3.o_tag),   (s < 2) ? 64'h0 : {56'h0, ed[7:0] + 8'h A0});
    end
    chk("lat3.addr", 64'(b3.o_addr), 64'h204);

    // Reset while two reads are still in flight.
    drv3(1, 0, 0, 0, 64'h200, 8'h00);
    tick();
    drv3(0, 0, 1, 1, 64'h0, 8'h00);
    tick();
    drv3(0, 0, 1, 1, 64'h0, 8'h00);
    tick();
    #2;
    rst3_n = 1'b0;
    #1;
    chk("flush.rst.valid", 64'(b3.o_valid), 64'h0);
    chk("flush.rst.data",  b3.o_data,       64'h0);
    chk("flush.rst.tag",   64'(b3.o_tag),   64'h0);
    chk("flush.rst.addr",  64'(b3.o_addr),  64'h0);
    b3.i_rd  = 1'b0;
    b3.i_btr = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      drv3(0, 0, 0, 0, 64'h0, 8'h00);
      tick();
      chk($sformatf("flush.s%0d.valid", s), 64'(b3.o_valid), 64'h0);
      chk($sformatf("flush.s%0d.data", s),  b3.o_data,       64'h0);
    end

`ifdef TAGGED_RAM_CTL_PARITY_EN
    drv1(1, 0, 0, 0, 64'h10, 8'h00);
    tick();
    drv1(0, 1, 0, 0, 64'h1, 8'h00);
    tick();
    u1.inject_parity(20'h10);
    drv1(0, 0, 1, 0, 64'h0, 8'h00);
    tick();
    chk("par.bad.valid", 64'(b1.o_valid), 64'h1);
    chk("par.bad.err",   64'(b1.o_err),   64'h1);
    drv1(0, 0, 0, 0, 64'h0, 8'h00);
    tick();
    chk("par.sticky.err", 64'(b1.o_err), 64'h1);
    drv1(1, 0, 0, 0, 64'h20, 8'h00);
    tick();
    drv1(0, 1, 0, 0, 64'h5, 8'h00);
    tick();
    drv1(0, 0, 1, 0, 64'h0, 8'h00);
    tick();
    chk("par.clean.data", b1.o_data,       64'h5);
    chk("par.clean.err",  64'(b1.o_err),   64'h1);
    drv1(0, 0, 0, 0, 64'h0, 8'h00);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tagged_ram_ctl.md
Name: tagged_ram_ctl

Overview:
- Synthesizable, parametrised tagged main-memory slave for the CPU's multiplexed address/data bus (address strobe, read, write, 64-bit word plus 8-bit tag).
- Generalises the bench-level tagged RAM model with:
  - configurable address, data and tag widths;
  - a configurable read-latency pipeline with a valid strobe;
  - block-transfer (BTR) auto-increment addressing.
- Sits between the cpu bus outputs and its i_data/i_tag inputs, in benches and in FPGA builds.

Parameters:
- AW, 20, word-address width; depth is 2**AW words.
- DW, 64, data word width.
- TW, 8, tag width.
- RD_LAT, 1, read latency in clocks from rd sample to o_valid; legal 1..4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_ad  in  DW  address (on astb) or write data (on wr); address taken from i_ad[AW-1:0].
- i_tag  in  TW  write tag.
- i_astb  in  1  address strobe.
- i_rd  in  1  read request.
- i_wr  in  1  write request.
- i_btr  in  1  block-transfer mode: post-increment address after each rd/wr.
- o_data  out  DW  read data, held until the next read completes.
- o_tag  out  TW  read tag, held likewise.
- o_valid  out  1  one-cycle pulse when o_data/o_tag are updated.
- o_addr  out  AW  current latched word address (debug/trace).
- o_err  out  1  sticky parity error (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous):
  - o_data=0, o_tag=0, o_valid=0, o_addr=0, o_err=0.
  - Read pipeline flushed: in-flight reads are discarded and never produce o_valid.
  - RAM/tag contents are not cleared.
- Per-cycle command priority: i_astb > i_wr > i_rd. Lower-priority strobes in the same cycle are ignored (no access, no increment).
- astb: o_addr <= i_ad[AW-1:0]. No memory access.
- wr: mem[o_addr] <= i_ad and tag[o_addr] <= i_tag at this edge. If i_btr=1, o_addr <= o_addr+1.
- rd:
  - Data is sampled from mem[o_addr] at this edge and enters a RD_LAT-deep shift pipeline (valid bit + data + tag).
  - o_valid=1 exactly RD_LAT cycles after the rd edge; o_data/o_tag update in the same cycle.
  - If i_btr=1, o_addr <= o_addr+1.
- Address increment wraps modulo 2**AW (all-ones -> 0).
- Back-to-back reads: one rd per cycle is accepted; o_valid pulses once per rd, in issue order, no bubbles.
- Read-after-write: a wr at edge N followed by a rd of the same address at edge N+1 returns the new data. A wr and a queued read never reorder.
- astb while reads are in flight: in-flight reads complete normally with the data already sampled.
- Idle cycles: o_valid=0; o_data/o_tag hold their values.
- RD_LAT outside 1..4: elaboration error ($error in a generate block).

Optional Feature:
- Macro: TAGGED_RAM_CTL_PARITY_EN.
- Enabled:
  - An extra parity bit per word is stored on wr: XOR over data and tag.
  - On read completion the parity is recomputed. On mismatch o_err sets (sticky) in the o_valid cycle. It clears only on reset.
  - A hierarchical-access task inject_parity(addr) flips the stored parity bit for bench use.
- Disabled: no parity storage; o_err is constant 0.

Test Plan:
- Reset then idle 5 cycles -> o_valid=0, o_data=0, o_tag=0, o_addr=0, o_err=0.
- astb 0x00123, wr 64'hDEADBEEF_01234567 tag 8'h3C, rd (RD_LAT=1) -> o_valid 1 cycle after rd, o_data=DEADBEEF01234567, o_tag=3C.
- astb 0xFFFFE, i_btr=1, wr 0xA (tag 1), 0xB (2), 0xC (3) -> words at 0xFFFFE, 0xFFFFF, 0x00000; o_addr=0x00001. Then astb 0xFFFFE and 3 btr reads return A/1, B/2, C/3 in order.
- RD_LAT=3: 4 consecutive btr reads -> o_valid high on cycles 3..6 after the first rd, data in order. Assert reset during cycle 2 -> no further o_valid, all outputs 0.
- Same cycle: astb+wr with i_ad=0x55 -> only o_addr=0x55, no memory change. Next cycle: rd+wr with i_ad=0x77 -> write of 0x77 performed, no o_valid.
- With TAGGED_RAM_CTL_PARITY_EN: write 0x1 at 0x10, inject_parity(0x10), read -> o_err=1 in the o_valid cycle and stays 1. Clean read of another address -> o_err remains 1.
